// File: rtl/vi_csr_pkg.sv
// Shared widths, poison value and FSM state type for the CSR leaf decoder.
package vi_csr_pkg;

  localparam int unsigned CSR_ADDR_W = 21;
  localparam int unsigned CSR_DATA_W = 64;
  localparam logic [CSR_DATA_W-1:0] CSR_POISON = 64'hDEAD_DEAD_DEAD_DEAD;

  typedef enum logic {
    IDLE,
    WAIT
  } csr_state_e;

endpackage

// File: rtl/vi_sat_cnt.sv
// Saturating up-counter with a multi-bit increment, for error/event tallies.
module vi_sat_cnt #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned INC_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (WIDTH + 1)'(inc_i);
    cnt_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vi_csr_decode.sv
// CSR fan-out decoder: forwards one-cycle strobes to a selected leaf target and
// returns exactly one upstream ack per accepted request (real, decode error or timeout).
module vi_csr_decode
  import vi_csr_pkg::*;
#(
  parameter int unsigned NUM_TGT = 4,
  parameter int unsigned SEL_LSB = 18,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iWREN,
  input  logic                          iRDEN,
  input  logic [CSR_ADDR_W-1:0]         iADDR,
  input  logic [CSR_DATA_W-1:0]         iWR_DATA,
  output logic                          oACK,
  output logic [CSR_DATA_W-1:0]         oRD_DATA,
  output logic [NUM_TGT-1:0]            oWREN,
  output logic [NUM_TGT-1:0]            oRDEN,
  output logic [CSR_ADDR_W-1:0]         oADDR,
  output logic [CSR_DATA_W-1:0]         oWR_DATA,
  input  logic [NUM_TGT-1:0]            iACK,
  input  logic [CSR_DATA_W*NUM_TGT-1:0] iRD_DATA,
  output logic [15:0]                   oERR_CNT
);

  localparam int unsigned SEL_W = CSR_ADDR_W - SEL_LSB;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  csr_state_e             state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   ack_q, ack_d;
  logic [CSR_DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [NUM_TGT-1:0]     wren_q, wren_d;
  logic [NUM_TGT-1:0]     rden_q, rden_d;
  logic [CSR_ADDR_W-1:0]  addr_q, addr_d;
  logic [CSR_DATA_W-1:0]  wdata_q, wdata_d;
  logic [NUM_TGT-1:0]     sel_oh_q, sel_oh_d;
  logic                   is_rd_q, is_rd_d;

  logic                   strobe, dual, req_rd, sel_ok, tgt_ack, expired;
  logic [SEL_W-1:0]       req_sel;
  logic [NUM_TGT-1:0]     req_oh;
  logic [CSR_DATA_W-1:0]  tgt_data;
  logic                   err_dec, err_dual, err_drop, err_to;
  logic [1:0]             err_inc;

  assign strobe  = iWREN | iRDEN;
  assign dual    = iWREN & iRDEN;
  assign req_rd  = iRDEN & ~iWREN;
  assign req_sel = iADDR[CSR_ADDR_W-1:SEL_LSB];
  assign expired = (timer_q == TMR_W'(TIMEOUT - 1));

  // One-hot select avoids indexing NUM_TGT-wide vectors with the wider select field.
  always_comb begin
    req_oh = '0;
    for (int k = 0; k < NUM_TGT; k++) begin
      req_oh[k] = (req_sel == SEL_W'(k));
    end
  end
  assign sel_ok = |req_oh;

  always_comb begin
    tgt_data = '0;
    for (int k = 0; k < NUM_TGT; k++) begin
      if (sel_oh_q[k]) begin
        tgt_data = tgt_data | iRD_DATA[k*CSR_DATA_W +: CSR_DATA_W];
      end
    end
  end
  assign tgt_ack = |(iACK & sel_oh_q);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ack_d     = 1'b0;
    rd_data_d = rd_data_q;
    wren_d    = '0;
    rden_d    = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_oh_d  = sel_oh_q;
    is_rd_d   = is_rd_q;
    err_dec   = 1'b0;
    err_dual  = 1'b0;
    err_drop  = 1'b0;
    err_to    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          addr_d   = iADDR;
          wdata_d  = iWR_DATA;
          sel_oh_d = req_oh;
          is_rd_d  = req_rd;
          err_dual = dual;
          if (sel_ok) begin
            wren_d  = req_rd ? '0 : req_oh;
            rden_d  = req_rd ? req_oh : '0;
            timer_d = '0;
            state_d = WAIT;
          end else begin
            ack_d     = 1'b1;
            rd_data_d = CSR_POISON;
            err_dec   = 1'b1;
          end
        end
      end
      WAIT: begin
        err_drop = strobe;
        // A real ack on the expiry cycle takes priority over the timeout.
        if (tgt_ack) begin
          state_d = IDLE;
          ack_d   = 1'b1;
          if (is_rd_q) begin
            rd_data_d = tgt_data;
          end
        end else if (expired) begin
          state_d = IDLE;
          ack_d   = 1'b1;
          err_to  = 1'b1;
          if (is_rd_q) begin
            rd_data_d = CSR_POISON;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // At most two error events coincide: decode+dual in IDLE, or drop+timeout in WAIT.
  assign err_inc = 2'(err_dec) + 2'(err_dual) + 2'(err_drop) + 2'(err_to);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      ack_q     <= 1'b0;
      rd_data_q <= '0;
      wren_q    <= '0;
      rden_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_oh_q  <= '0;
      is_rd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ack_q     <= ack_d;
      rd_data_q <= rd_data_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_oh_q  <= sel_oh_d;
      is_rd_q   <= is_rd_d;
    end
  end

  vi_sat_cnt #(
    .WIDTH(16),
    .INC_W(2)
  ) u_err_cnt (
    .clk_i(iCLK),
    .rst_i(iRST),
    .clr_i(1'b0),
    .inc_i(err_inc),
    .cnt_o(oERR_CNT)
  );

  assign oACK     = ack_q;
  assign oRD_DATA = rd_data_q;
  assign oWREN    = wren_q;
  assign oRDEN    = rden_q;
  assign oADDR    = addr_q;
  assign oWR_DATA = wdata_q;

endmodule

// File: tb/tb_vi_csr_decode.sv
// Self-checking bench for vi_csr_decode: directed table, randomized transactions, reset abort.
module tb_vi_csr_decode;
  import vi_csr_pkg::*;

  localparam int NT = 4;
  localparam int SL = 18;
  localparam int TO = 255;

  logic                   clk = 1'b0;
  logic                   iRST;
  logic                   iWREN, iRDEN;
  logic [20:0]            iADDR;
  logic [63:0]            iWR_DATA;
  logic                   oACK;
  logic [63:0]            oRD_DATA;
  logic [NT-1:0]          oWREN, oRDEN;
  logic [20:0]            oADDR;
  logic [63:0]            oWR_DATA;
  logic [NT-1:0]          iACK;
  logic [64*NT-1:0]       iRD_DATA;
  logic [15:0]            oERR_CNT;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vi_csr_decode #(
    .NUM_TGT(NT),
    .SEL_LSB(SL),
    .TIMEOUT(TO)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iWREN(iWREN), .iRDEN(iRDEN), .iADDR(iADDR),
    .iWR_DATA(iWR_DATA), .oACK(oACK), .oRD_DATA(oRD_DATA), .oWREN(oWREN),
    .oRDEN(oRDEN), .oADDR(oADDR), .oWR_DATA(oWR_DATA), .iACK(iACK),
    .iRD_DATA(iRD_DATA), .oERR_CNT(oERR_CNT)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [20:0] addr;
    logic [63:0] wdata;
    int          lat;       // target acks lat cycles after its strobe cycle; -1 = silent
    logic [63:0] tdata;
    bit          spur;      // another target acks in the second wait cycle
    bit          late;      // target acks again in the cycle oACK is high
    int          intr;      // wait cycle in which a stray write strobe arrives; 0 = none
    int          exp_delay; // cycles from strobe cycle to oACK
    logic [3:0]  exp_w;
    logic [3:0]  exp_r;
    logic [63:0] exp_data;
    int          exp_err;
  } txn_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_rd_data();
    for (int k = 0; k < NT; k++) iRD_DATA[k*64 +: 64] = {$urandom, $urandom};
  endtask

  task automatic run_txn(input txn_t t);
    int          sel;
    int          delay;
    logic [63:0] data;
    bit          stray;
    sel   = int'(t.addr[20:SL]);
    delay = -1;
    data  = '0;
    stray = 1'b0;
    iWREN = t.wr; iRDEN = t.rd; iADDR = t.addr; iWR_DATA = t.wdata;
    tick();
    iWREN = 1'b0; iRDEN = 1'b0; iADDR = 21'($urandom); iWR_DATA = {$urandom, $urandom};
    chk("strobe_wr", 64'(oWREN), 64'(t.exp_w));
    chk("strobe_rd", 64'(oRDEN), 64'(t.exp_r));
    if (sel < NT) begin
      chk("oaddr", 64'(oADDR), 64'(t.addr));
      chk("owr_data", oWR_DATA, t.wdata);
    end
    for (int c = 1; c <= TO + 10; c++) begin
      if (c >= 2 && (oWREN != '0 || oRDEN != '0)) stray = 1'b1;
      if (oACK) begin
        delay = c;
        data  = oRD_DATA;
        break;
      end
      iACK = '0;
      rand_rd_data();
      if (sel < NT && t.lat >= 0 && c == t.lat + 1) begin
        iACK[sel] = 1'b1;
        iRD_DATA[sel*64 +: 64] = t.tdata;
      end
      if (sel < NT && t.spur && c == 2) iACK[(sel + 3) % NT] = 1'b1;
      if (t.intr > 0 && c == t.intr) begin
        iWREN = 1'b1;
        iADDR = 21'h0;
      end else begin
        iWREN = 1'b0;
      end
      tick();
    end
    iACK  = '0;
    iWREN = 1'b0;
    chk("ack_delay", 64'(delay), 64'(t.exp_delay));
    chk("rd_data", data, t.exp_data);
    chk("no_stray_strobe", 64'(stray), 64'd0);
    chk("err_cnt", 64'(oERR_CNT), 64'(t.exp_err));
    if (sel < NT) chk("oaddr_hold", 64'(oADDR), 64'(t.addr));
    if (t.late && sel < NT) iACK[sel] = 1'b1;
    tick();
    iACK = '0;
    chk("ack_one_cycle", 64'(oACK), 64'd0);
    chk("err_cnt_after", 64'(oERR_CNT), 64'(t.exp_err));
  endtask

  // Reference model: expected outcome from the request kind, target select and target latency.
  logic [63:0] hold;
  int          model_err;

  task automatic model(inout txn_t t);
    int sel;
    bit kind_rd;
    sel     = int'(t.addr[20:SL]);
    kind_rd = t.rd && !t.wr;
    if (t.rd && t.wr) model_err++;
    if (sel >= NT) begin
      t.exp_w = '0; t.exp_r = '0; t.exp_delay = 1;
      hold = CSR_POISON;
      model_err++;
    end else begin
      t.exp_w = kind_rd ? 4'b0 : 4'(1 << sel);
      t.exp_r = kind_rd ? 4'(1 << sel) : 4'b0;
      if (t.intr > 0 && (t.lat < 0 || t.intr <= t.lat + 1) && t.intr <= TO) model_err++;
      if (t.lat >= 0 && t.lat + 1 <= TO) begin
        t.exp_delay = t.lat + 2;
        if (kind_rd) hold = t.tdata;
      end else begin
        t.exp_delay = TO + 1;
        if (kind_rd) hold = CSR_POISON;
        model_err++;
      end
    end
    t.exp_data = hold;
    t.exp_err  = (model_err > 65535) ? 65535 : model_err;
  endtask

  txn_t tbl[9];
  txn_t rt;

  initial begin
    tbl[0] = '{rd:1, wr:0, addr:21'h04_0010, wdata:64'h0, lat:3, tdata:64'h0123_4567_89AB_CDEF,
               spur:0, late:0, intr:0, exp_delay:5, exp_w:4'b0000, exp_r:4'b0010,
               exp_data:64'h0123_4567_89AB_CDEF, exp_err:0};
    tbl[1] = '{rd:0, wr:1, addr:21'h1F_FFFF, wdata:64'h55, lat:0, tdata:64'h0,
               spur:0, late:0, intr:0, exp_delay:1, exp_w:4'b0000, exp_r:4'b0000,
               exp_data:CSR_POISON, exp_err:1};
    tbl[2] = '{rd:1, wr:0, addr:21'h08_0000, wdata:64'h0, lat:-1, tdata:64'h0,
               spur:0, late:1, intr:0, exp_delay:256, exp_w:4'b0000, exp_r:4'b0100,
               exp_data:CSR_POISON, exp_err:2};
    tbl[3] = '{rd:1, wr:0, addr:21'h00_0004, wdata:64'h0, lat:254, tdata:64'hA5A5_A5A5_5A5A_5A5A,
               spur:1, late:0, intr:0, exp_delay:256, exp_w:4'b0000, exp_r:4'b0001,
               exp_data:64'hA5A5_A5A5_5A5A_5A5A, exp_err:2};
    tbl[4] = '{rd:0, wr:1, addr:21'h0C_0100, wdata:64'hCAFE_F00D, lat:6, tdata:64'h0,
               spur:0, late:0, intr:2, exp_delay:8, exp_w:4'b1000, exp_r:4'b0000,
               exp_data:64'hA5A5_A5A5_5A5A_5A5A, exp_err:3};
    tbl[5] = '{rd:1, wr:1, addr:21'h04_0000, wdata:64'h77, lat:1, tdata:64'hFFFF_FFFF_FFFF_FFFF,
               spur:0, late:0, intr:0, exp_delay:3, exp_w:4'b0010, exp_r:4'b0000,
               exp_data:64'hA5A5_A5A5_5A5A_5A5A, exp_err:4};
    tbl[6] = '{rd:0, wr:1, addr:21'h00_0008, wdata:64'h99, lat:-1, tdata:64'h0,
               spur:0, late:0, intr:0, exp_delay:256, exp_w:4'b0001, exp_r:4'b0000,
               exp_data:64'hA5A5_A5A5_5A5A_5A5A, exp_err:5};
    tbl[7] = '{rd:1, wr:0, addr:21'h10_0000, wdata:64'h0, lat:0, tdata:64'h0,
               spur:0, late:0, intr:0, exp_delay:1, exp_w:4'b0000, exp_r:4'b0000,
               exp_data:CSR_POISON, exp_err:6};
    tbl[8] = '{rd:1, wr:0, addr:21'h0C_0020, wdata:64'h0, lat:0, tdata:64'h1111,
               spur:0, late:0, intr:0, exp_delay:2, exp_w:4'b0000, exp_r:4'b1000,
               exp_data:64'h1111, exp_err:6};

    iRST = 1'b1; iWREN = 1'b0; iRDEN = 1'b0; iADDR = '0; iWR_DATA = '0;
    iACK = '0; iRD_DATA = '0;
    tick();
    tick();
    chk("reset_ack", 64'(oACK), 64'd0);
    chk("reset_rd_data", oRD_DATA, 64'd0);
    chk("reset_strobes", 64'({oWREN, oRDEN}), 64'd0);
    chk("reset_addr", 64'(oADDR), 64'd0);
    chk("reset_wr_data", oWR_DATA, 64'd0);
    chk("reset_err_cnt", 64'(oERR_CNT), 64'd0);
    iRST = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    hold      = 64'h1111;
    model_err = 6;
    for (int i = 0; i < 40; i++) begin
      int m;
      int l;
      m = int'($urandom_range(0, 9));
      rt.rd    = (m == 0) || (m >= 5);
      rt.wr    = (m <= 4);
      rt.addr  = {3'($urandom_range(0, 7)), 18'($urandom)};
      rt.wdata = {$urandom, $urandom};
      rt.tdata = {$urandom, $urandom};
      l = int'($urandom_range(0, 19));
      if (l == 0)      rt.lat = -1;
      else if (l == 1) rt.lat = int'($urandom_range(252, 256));
      else             rt.lat = int'($urandom_range(0, 12));
      rt.spur  = $urandom_range(0, 3) == 0;
      rt.late  = $urandom_range(0, 3) == 0;
      rt.intr  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
      model(rt);
      run_txn(rt);
    end

    // Reset in the middle of a wait aborts the request without an ack.
    iRDEN = 1'b1; iADDR = 21'h04_0000;
    tick();
    iRDEN = 1'b0;
    tick();
    tick();
    #2 iRST = 1'b1;
    #1;
    chk("abort_ack", 64'(oACK), 64'd0);
    chk("abort_rd_data", oRD_DATA, 64'd0);
    chk("abort_strobes", 64'({oWREN, oRDEN}), 64'd0);
    chk("abort_addr", 64'(oADDR), 64'd0);
    chk("abort_wr_data", oWR_DATA, 64'd0);
    chk("abort_err_cnt", 64'(oERR_CNT), 64'd0);
    @(posedge clk);
    #1 iRST = 1'b0;
    iACK[1] = 1'b1;
    tick();
    iACK = '0;
    tick();
    chk("abort_no_ack", 64'(oACK), 64'd0);
    hold      = '0;
    model_err = 0;
    rt = '{rd:1, wr:0, addr:21'h08_0040, wdata:64'h0, lat:2, tdata:64'h0BAD_F00D_1234_5678,
           spur:0, late:0, intr:0, exp_delay:0, exp_w:4'b0, exp_r:4'b0, exp_data:64'h0,
           exp_err:0};
    model(rt);
    run_txn(rt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
